// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, priority bus mux and a combinational ALU feeding Z.
// Optional signed mul/div opcodes are built only when CPU_DATAPATH_MULDIV_EN is defined.
module cpu_datapath #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              MARout,
  input  logic              IRout,
  input  logic              RYout,
  input  logic              RZoutHi,
  input  logic              RZoutLo,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              R4out,
  input  logic              R5out,
  input  logic              R6out,
  input  logic              R7out,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              MARin,
  input  logic              IRin,
  input  logic              RYin,
  input  logic              RZinHi,
  input  logic              RZinLo,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              R6in,
  input  logic              R7in,
  input  logic              MDRread,
  input  logic              IncPC,
  output logic [DATA_W-1:0] BusMuxOut
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [DATA_W-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [DATA_W-1:0] gpr_q [2:7];
  logic [7:2]        gpr_out, gpr_in;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] mdr_d;
  logic signed [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] c_hi, c_lo;
  logic [4:0]        opcode, sh_amt;

  assign gpr_out = {R7out, R6out, R5out, R4out, R3out, R2out};
  assign gpr_in  = {R7in, R6in, R5in, R4in, R3in, R2in};

  // Rotates reuse the 5-bit wrap of (0 - s) so a zero amount yields a | a.
  function automatic logic [DATA_W-1:0] rot_right(input logic [DATA_W-1:0] a, input logic [4:0] s);
    return (a >> s) | (a << (5'd0 - s));
  endfunction

  function automatic logic [DATA_W-1:0] rot_left(input logic [DATA_W-1:0] a, input logic [4:0] s);
    return (a << s) | (a >> (5'd0 - s));
  endfunction

  always_comb begin
    bus = '0;
    if (MDRout)       bus = mdr_q;
    else if (RZoutLo) bus = zlo_q;
    else if (RZoutHi) bus = zhi_q;
    else if (RYout)   bus = y_q;
    else if (PCout)   bus = pc_q;
    else if (IRout)   bus = ir_q;
    else if (MARout)  bus = mar_q;
    else begin
      // Descending scan so the lowest-numbered asserted register wins.
      for (int i = 7; i >= 2; i--) begin
        if (gpr_out[i]) bus = gpr_q[i];
      end
    end
  end

  assign BusMuxOut = bus;
  assign mdr_d     = MDRread ? Mdatain : bus;

  assign alu_a  = y_q;
  assign alu_b  = bus;
  assign opcode = ir_q[31:27];
  assign sh_amt = bus[4:0];

`ifdef CPU_DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   quot, rem;

  assign prod = {{DATA_W{alu_a[DATA_W-1]}}, alu_a} * {{DATA_W{alu_b[DATA_W-1]}}, alu_b};
  assign quot = (alu_b == '0) ? '1 : alu_a / alu_b;
  assign rem  = (alu_b == '0) ? alu_a : alu_a % alu_b;
`endif

  always_comb begin
    c_hi = '0;
    c_lo = '0;
    if (IncPC) begin
      c_lo = alu_b + 32'sd1;
    end else begin
      unique case (opcode)
        OP_ADD:  c_lo = alu_a + alu_b;
        OP_SUB:  c_lo = alu_a - alu_b;
        OP_AND:  c_lo = alu_a & alu_b;
        OP_OR:   c_lo = alu_a | alu_b;
        OP_ROR:  c_lo = rot_right(alu_a, sh_amt);
        OP_ROL:  c_lo = rot_left(alu_a, sh_amt);
        OP_SHR:  c_lo = alu_a >> sh_amt;
        OP_SHRA: c_lo = alu_a >>> sh_amt;
        OP_SHL:  c_lo = alu_a << sh_amt;
        OP_NEG:  c_lo = -alu_b;
        OP_NOT:  c_lo = ~alu_b;
`ifdef CPU_DATAPATH_MULDIV_EN
        OP_MUL: begin
          c_hi = prod[2*DATA_W-1:DATA_W];
          c_lo = prod[DATA_W-1:0];
        end
        OP_DIV: begin
          c_hi = rem;
          c_lo = quot;
        end
`else
        OP_MUL, OP_DIV: begin
          c_hi = '0;
          c_lo = '0;
        end
`endif
        default: c_lo = alu_a + alu_b;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      for (int i = 2; i <= 7; i++) gpr_q[i] <= '0;
    end else begin
      if (PCin)   pc_q  <= bus;
      if (IRin)   ir_q  <= bus;
      if (MARin)  mar_q <= bus;
      if (MDRin)  mdr_q <= mdr_d;
      if (RYin)   y_q   <= bus;
      if (RZinHi) zhi_q <= c_hi;
      if (RZinLo) zlo_q <= c_lo;
      if (HIin)   hi_q  <= bus;
      if (LOin)   lo_q  <= bus;
      for (int i = 2; i <= 7; i++) begin
        if (gpr_in[i]) gpr_q[i] <= bus;
      end
    end
  end

  // HI/LO have no bus driver and only the opcode field of IR feeds the ALU.
  logic unused_bits;
  assign unused_bits = ^{hi_q, lo_q, ir_q[26:0]};

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with a queue-based scoreboard on BusMuxOut.
module tb_cpu_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic PCout, MDRout, MARout, IRout, RYout, RZoutHi, RZoutLo;
  logic R2out, R3out, R4out, R5out, R6out, R7out;
  logic PCin, MDRin, MARin, IRin, RYin, RZinHi, RZinLo, HIin, LOin;
  logic R2in, R3in, R4in, R5in, R6in, R7in;
  logic MDRread, IncPC;
  logic [31:0] BusMuxOut;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain),
    .PCout(PCout), .MDRout(MDRout), .MARout(MARout), .IRout(IRout), .RYout(RYout),
    .RZoutHi(RZoutHi), .RZoutLo(RZoutLo),
    .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .PCin(PCin), .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .RYin(RYin),
    .RZinHi(RZinHi), .RZinLo(RZinLo), .HIin(HIin), .LOin(LOin),
    .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .MDRread(MDRread), .IncPC(IncPC), .BusMuxOut(BusMuxOut)
  );

  always #10 clock = ~clock;

  logic [31:0] exp_q [$];
  string       name_q [$];
  event        sample_ev;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Monitor: pops one expectation each time the stimulus presents a bus value.
  initial begin
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_tests++;
        if (BusMuxOut !== e) begin
          n_fail++;
          $display("FAIL %s: BusMuxOut=%h expected %h", n, BusMuxOut, e);
        end
      end
    end
  end

  task automatic idle();
    {PCout, MDRout, MARout, IRout, RYout, RZoutHi, RZoutLo} = '0;
    {R2out, R3out, R4out, R5out, R6out, R7out} = '0;
    {PCin, MDRin, MARin, IRin, RYin, RZinHi, RZinLo, HIin, LOin} = '0;
    {R2in, R3in, R4in, R5in, R6in, R7in} = '0;
    MDRread = 1'b0;
    IncPC   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic check(input string n, input logic [31:0] e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    -> sample_ev;
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; MDRread = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic alu_case(input string n, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_lo, input logic [31:0] e_hi);
    load_mdr({op, 27'd0});
    MDRout = 1'b1; IRin = 1'b1; tick();
    load_mdr(a);
    MDRout = 1'b1; RYin = 1'b1; tick();
    load_mdr(b);
    MDRout = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; tick();
    RZoutLo = 1'b1;
    check($sformatf("%s_lo", n), e_lo);
    RZoutLo = 1'b0; RZoutHi = 1'b1;
    check($sformatf("%s_hi", n), e_hi);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    clear   = 1'b0;
    Mdatain = '0;
    @(negedge clock);

    // Reset state, and registers held at zero while clear stays low.
    PCout = 1'b1; check("rst_pc", 32'h0); PCout = 1'b0;
    RZoutLo = 1'b1; check("rst_zlo", 32'h0); RZoutLo = 1'b0;
    Mdatain = 32'h55; MDRread = 1'b1; MDRin = 1'b1; tick();
    MDRout = 1'b1; check("rst_hold_mdr", 32'h0);
    clear = 1'b1;
    tick();

    // Register load through MDR into R3.
    load_mdr(32'h22);
    MDRout = 1'b1; R3in = 1'b1; tick();
    R3out = 1'b1; check("load_r3", 32'h22); tick();
    check("bus_idle", 32'h0);

    // shr: R4 = R3 >> R7.
    load_mdr(32'h2);
    MDRout = 1'b1; R7in = 1'b1; tick();
    load_mdr(32'h4A2B8000);
    MDRout = 1'b1; IRin = 1'b1; tick();
    R3out = 1'b1; RYin = 1'b1; tick();
    R7out = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; tick();
    RZoutLo = 1'b1; R4in = 1'b1; tick();
    R4out = 1'b1; check("shr_r4", 32'h8); tick();
    RZoutHi = 1'b1; check("shr_zhi", 32'h0); tick();

    // Priority among simultaneous drivers.
    load_mdr(32'h12);
    MDRout = 1'b1; R2in = 1'b1; tick();
    load_mdr(32'h99);
    MDRout = 1'b1; R2out = 1'b1; check("prio_mdr_r2", 32'h99); tick();
    R2out = 1'b1; R7out = 1'b1; check("prio_r2_r7", 32'h12); tick();
    R3out = 1'b1; PCout = 1'b1; check("prio_pc_r3", 32'h0); tick();

    // ALU opcode table.
    alu_case("add_wrap", 5'b00011, 32'hFFFFFFFF, 32'h2,        32'h1,        32'h0);
    alu_case("sub",      5'b00100, 32'h3,        32'h5,        32'hFFFFFFFE, 32'h0);
    alu_case("and",      5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0);
    alu_case("or",       5'b00110, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 32'h0);
    alu_case("ror_b5",   5'b00111, 32'h00000001, 32'h00000021, 32'h80000000, 32'h0);
    alu_case("rol",      5'b01000, 32'h80000001, 32'h4,        32'h00000018, 32'h0);
    alu_case("shra",     5'b01010, 32'h80000000, 32'h4,        32'hF8000000, 32'h0);
    alu_case("shl_zero", 5'b01011, 32'h00000003, 32'h20,       32'h00000003, 32'h0);
    alu_case("neg",      5'b10001, 32'h5,        32'h1,        32'hFFFFFFFF, 32'h0);
    alu_case("not",      5'b10010, 32'h5,        32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0);
    alu_case("dflt_add", 5'b00000, 32'h10,       32'h20,       32'h30,       32'h0);
`ifdef CPU_DATAPATH_MULDIV_EN
    alu_case("mul",      5'b01111, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF);
    alu_case("div_zero", 5'b10000, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE);
    alu_case("div",      5'b10000, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
`else
    alu_case("mul_off",  5'b01111, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h0);
    alu_case("div_off",  5'b10000, 32'h7,        32'hFFFFFFFE, 32'h0,        32'h0);
`endif

    // IncPC overrides the subtract opcode; MAR captures old PC.
    load_mdr({5'b00100, 27'd0});
    MDRout = 1'b1; IRin = 1'b1; tick();
    load_mdr(32'h5);
    MDRout = 1'b1; PCin = 1'b1; tick();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; tick();
    RZoutLo = 1'b1; check("inc_zlo", 32'h6); tick();
    RZoutHi = 1'b1; check("inc_zhi", 32'h0); tick();
    MARout = 1'b1; check("inc_mar", 32'h5); tick();

    // Source driving the bus while reloading presents its old value.
    RZoutLo = 1'b1; IncPC = 1'b1; RZinLo = 1'b1; check("same_cyc_old", 32'h6); tick();
    RZoutLo = 1'b1; check("same_cyc_new", 32'h7); tick();

    // Asynchronous reset between clock edges.
    load_mdr(32'hFFFFFFFF);
    MDRout = 1'b1; R5in = 1'b1; tick();
    R5out = 1'b1; check("r5_loaded", 32'hFFFFFFFF);
    clear = 1'b0;
    check("async_r5", 32'h0);
    R5out = 1'b0; MDRout = 1'b1; check("async_mdr", 32'h0);
    MDRout = 1'b0;
    #2 clear = 1'b1;
    load_mdr(32'hAB);
    MDRout = 1'b1; check("resume_mdr", 32'hAB); tick();

    repeat (2) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have ports: clock input 1, rising-edge system clock; clear input 1, asynchronous active-low reset.
REQ-002 SHALL have Mdatain input 32, memory read data.
REQ-003 SHALL have bus-drive selects, input 1 each: PCout, MDRout, MARout, IRout, RYout, RZoutHi, RZoutLo, R2out..R7out.
REQ-004 SHALL have load enables, input 1 each: PCin, MDRin, MARin, IRin, RYin, RZinHi, RZinLo, HIin, LOin, R2in..R7in.
REQ-005 SHALL have control inputs, 1 bit each: MDRread (MDR source select); IncPC (force ALU increment).
REQ-006 SHALL have BusMuxOut output 32, the current internal bus value, for observation.

Function
REQ-007 SHALL contain 32-bit registers PC, IR, MAR, MDR, Y, Zhi, Zlo, HI, LO, R2..R7; each loads on the rising clock edge when its *in is 1, otherwise holds.
REQ-008 Bus SHALL be combinational: value of the single asserted *out source; 0 if none. Priority if several are asserted, highest first: MDR, Zlo, Zhi, Y, PC, IR, MAR, R2..R7 ascending.
REQ-009 MDR input SHALL be Mdatain when MDRread=1, else the bus.
REQ-010 PC, IR, MAR, Y, HI, LO, R2..R7 SHALL load from the bus.
REQ-011 ALU SHALL be combinational, A=Y, B=bus, 64-bit result {C_hi,C_lo}; Zhi loads C_hi, Zlo loads C_lo.
REQ-012 IncPC=1 SHALL force C_lo=B+1, C_hi=0, regardless of opcode.
REQ-013 Otherwise opcode SHALL be IR[31:27], C_hi=0 unless stated: 00011 add A+B; 00100 sub A-B; 00101 and; 00110 or; 00111 ror A by B[4:0]; 01000 rol; 01001 shr logical A>>B[4:0]; 01010 shra arithmetic; 01011 shl A<<B[4:0]; 10001 neg -B; 10010 not ~B; all other opcodes A+B.
REQ-014 Add and sub SHALL wrap modulo 2^32 with no carry or overflow output.
REQ-015 Shifts and rotates SHALL use only B[4:0]; an amount of 0 returns A unchanged.
REQ-016 Register write SHALL take effect on the clock edge; a source driving the bus and loading in the same cycle SHALL output its old value.

Reset
REQ-017 clear=0 SHALL asynchronously zero every register (PC, IR, MAR, MDR, Y, Zhi, Zlo, HI, LO, R2..R7), holding them at 0 while clear stays low.
REQ-018 On clear rising, registers SHALL resume loading at the next clock edge.
REQ-019 BusMuxOut SHALL stay combinational during reset and reflect the zeroed registers.

Configuration
REQ-020 With macro CPU_DATAPATH_MULDIV_EN defined, the ALU SHALL implement opcode 01111 mul (signed 64-bit A*B; C_hi=high word, C_lo=low word).
REQ-021 With it defined, the ALU SHALL implement opcode 10000 div (signed; C_lo=quotient, C_hi=remainder); B=0 SHALL give C_lo=FFFFFFFF, C_hi=A.
REQ-022 Without the macro, opcodes 01111 and 10000 SHALL produce C_hi=C_lo=0, and no multiplier or divider logic is synthesized.

Verification
REQ-023 Register load: Mdatain=00000022, MDRread=MDRin=1 one cycle; then MDRout=R3in=1 one cycle; then R3out=1 -> BusMuxOut=00000022.
REQ-024 shr: R3=22, R7=2; IR=4A2B8000; R3out+RYin; R7out+RZinLo; RZoutLo+R4in; then R4out -> BusMuxOut=00000008.
REQ-025 Increment: PC=00000005; PCout+MARin+IncPC+RZinLo; then RZoutLo -> BusMuxOut=00000006, and MAR=5 seen on MARout.
REQ-026 Async reset: load R5=FFFFFFFF, drop clear between clock edges -> R5out gives 0 immediately, before the next edge.
REQ-027 With CPU_DATAPATH_MULDIV_EN: Y=FFFFFFFE (-2), bus=3, opcode 01111 -> Zhi=FFFFFFFF, Zlo=FFFFFFFA; opcode 10000 with bus=0 -> Zlo=FFFFFFFF, Zhi=FFFFFFFE.
REQ-028 Bus idle and priority: no *out asserted -> BusMuxOut=0; MDRout and R2out together -> MDR value.
